mult3_seq_ctrl: RTL



---
 rtl/mult3_seq_ctrl_pkg.sv | 15 +
 rtl/mult3_seq_ctrl_add_nbit.sv | 30 +++
 rtl/mult3_seq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mult3_seq_ctrl_pkg.sv
// Shared definitions for the mult3_seq_ctrl sequential multiplier.
// Contents:
//   WIDTH_DEF - default operand width
//   state_t   - controller state encoding (2'd3 is illegal and recovers to IDLE)
package mult3_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : mult3_seq_ctrl_pkg

// File: rtl/mult3_seq_ctrl_add_nbit.sv
// Parameterised combinational ripple-carry adder.
// Ports:
//   A, B - WIDTH-bit unsigned addends
//   sum  - WIDTH-bit sum
//   cy   - carry out of the most significant bit
module add_nbit
    import mult3_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             cy
);

    logic [WIDTH:0] carry_s;

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        carry_s    = {(WIDTH+1){1'b0}};
        sum        = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = A[i] ^ B[i] ^ carry_s[i];
            carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
        end
        cy = carry_s[WIDTH];
    end

endmodule : add_nbit

// File: rtl/mult3_seq_ctrl.sv
// Sequential shift-and-add multiplier controller.
// One adder pass per multiplier bit; product presented with a one-cycle done pulse.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - request a multiply (accepted only while ready=1)
//   A, B         - multiplicand / multiplier, captured on the accepting edge
//   ready        - high in IDLE and DONE
//   busy         - high in ADD
//   done         - one-cycle pulse when product becomes valid
//   product      - {acc, q}, held until the next multiply completes
module mult3_seq_ctrl
    import mult3_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // One extra bit so the counter reaches WIDTH-1 without wrapping for any WIDTH.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] product_r;
    logic               ready_r;
    logic               busy_r;
    logic               done_r;

    logic               load_s;
    logic               step_s;
    logic               cap_s;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   sum_s;
    logic               cy_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH-1:0]   q_nxt_s;

    // Add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        if (q_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
    end

    add_nbit #(.WIDTH(WIDTH)) u_add (
        .A   (acc_r),
        .B   (addend_s),
        .sum (sum_s),
        .cy  (cy_s)
    );

    // {c,s,q} >> 1: carry enters the acc MSB, sum LSB enters the q MSB.
    always_comb begin
        acc_nxt_s = {cy_s, sum_s[WIDTH-1:1]};
        q_nxt_s   = {sum_s[0], q_r[WIDTH-1:1]};
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        cap_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ADD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                step_s = 1'b1;
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    cap_s       = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ADD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ADD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
            busy_r  <= (state_nxt_s == ST_ADD);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand load, shift-add iteration and product capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {WIDTH{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            if (load_s) begin
                mcand_r <= A;
                q_r     <= B;
                acc_r   <= {WIDTH{1'b0}};
                cnt_r   <= {CNT_W{1'b0}};
            end else if (step_s) begin
                acc_r   <= acc_nxt_s;
                q_r     <= q_nxt_s;
                cnt_r   <= cnt_r + CNT_W'(1);
            end
            // Product only moves on the final iteration, so it holds through IDLE
            // and the next multiply's ADD cycles.
            if (cap_s) begin
                product_r <= {acc_nxt_s, q_nxt_s};
            end
        end
    end

    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule : mult3_seq_ctrl
